// File: rtl/sprite_fetch_arb.sv
// Four-way sprite/background SRAM read arbiter: priority-or-round-robin grant,
// registered SRAM issue, grant-tag return pipeline and sticky starvation flags.
module sprite_fetch_arb #(
   parameter int ADDR_W   = 18,
   parameter int DATA_W   = 12,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en,
   input  logic                  pri0,
   input  logic [3:0]            req,
   input  logic [4*ADDR_W-1:0]   req_addr,
   output logic [3:0]            gnt,
   output logic                  sram_en,
   output logic [ADDR_W-1:0]     sram_addr,
   input  logic [DATA_W-1:0]     sram_dout,
   output logic [3:0]            rd_valid,
   output logic [DATA_W-1:0]     rd_data,
   input  logic                  stat_clr,
   output logic [3:0]            starve
);

   localparam int PIPE_D = RD_LAT + 1;

   logic [1:0]        r_rr;
   logic              r_sram_en;
   logic [ADDR_W-1:0] r_sram_addr;
   logic [3:0]        r_tag [PIPE_D];
   logic [7:0]        r_wait [4];
   logic [3:0]        r_starve;

   logic [3:0]        w_gnt;
   logic [1:0]        w_gnt_idx;
   logic              w_pri_hit;
   logic              w_found;
   logic [1:0]        w_scan;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [3:0]        w_starve_set;

   // Grant: requester 0 wins outright under pri0, otherwise search from rr.
   always_comb begin
      w_gnt     = '0;
      w_gnt_idx = '0;
      w_pri_hit = 1'b0;
      w_found   = 1'b0;
      w_scan    = '0;
      if (en && (req != 4'b0000)) begin
         if (pri0 && req[0]) begin
            w_pri_hit = 1'b1;
            w_gnt_idx = 2'd0;
         end else begin
            for (int k = 0; k < 4; k++) begin
               w_scan = r_rr + 2'(k);
               if (!w_found && req[w_scan]) begin
                  w_found   = 1'b1;
                  w_gnt_idx = w_scan;
               end
            end
         end
         w_gnt[w_gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      w_sel_addr = '0;
      for (int i = 0; i < 4; i++) begin
         if (w_gnt_idx == 2'(i)) begin
            w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rr        <= '0;
         r_sram_en   <= 1'b0;
         r_sram_addr <= '0;
      end else begin
         r_sram_en <= |w_gnt;
         if (|w_gnt) begin
            r_sram_addr <= w_sel_addr;
            if (!w_pri_hit) begin
               r_rr <= w_gnt_idx + 2'd1;
            end
         end
      end
   end

   // The tag rides alongside the SRAM access so the strobe lines up with sram_dout.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < PIPE_D; s++) begin
            r_tag[s] <= '0;
         end
      end else begin
         r_tag[0] <= w_gnt;
         for (int s = 1; s < PIPE_D; s++) begin
            r_tag[s] <= r_tag[s-1];
         end
      end
   end

   always_comb begin
      w_starve_set = '0;
      for (int i = 0; i < 4; i++) begin
         w_starve_set[i] = req[i] && !w_gnt[i] && (r_wait[i] == 8'(MAX_WAIT - 1));
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 4; i++) begin
            r_wait[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_gnt[i] || !req[i]) begin
               r_wait[i] <= '0;
            end else if (r_wait[i] != 8'hFF) begin
               r_wait[i] <= r_wait[i] + 8'd1;
            end
         end
      end
   end

   // A fresh starvation event outranks a simultaneous clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_starve <= '0;
      end else begin
         r_starve <= (r_starve & ~{4{stat_clr}}) | w_starve_set;
      end
   end

   assign gnt       = w_gnt;
   assign sram_en   = r_sram_en;
   assign sram_addr = r_sram_addr;
   assign rd_valid  = r_tag[PIPE_D-1];
   assign rd_data   = sram_dout;
   assign starve    = r_starve;

endmodule
